// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage_if
// Description : Operand bus from the decode/execute pipeline register to the
//               ALU. The master drives a valid operation; the slave consumes
//               it with out_ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_operand_stage_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  aluc;
  logic        wreg_out;
  logic [4:0]  rn_out;

  modport master (
    output out_valid, a, b, aluc, wreg_out, rn_out,
    input  out_ready
  );

  modport slave (
    input  out_valid, a, b, aluc, wreg_out, rn_out,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage
// Description : Decode-to-execute pipeline register. Resolves register
//               operands by forwarding from MEM/WB, selects shift amount or
//               extended immediate, stalls on load-use hazards and counts
//               the stall cycles (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  wire logic                   clock,
  input  wire logic                   resetn,
  // decode side
  input  wire logic                   in_valid,
  output logic                        in_ready,
  input  wire logic [4:0]             rs_num,
  input  wire logic [4:0]             rt_num,
  input  wire logic [31:0]            rs_data,
  input  wire logic [31:0]            rt_data,
  input  wire logic [15:0]            imm,
  input  wire logic [4:0]             sa,
  input  wire logic [3:0]             aluc_in,
  input  wire logic                   shift,
  input  wire logic                   aluimm,
  input  wire logic                   sext,
  input  wire logic                   wreg_in,
  input  wire logic [4:0]             rn_in,
  // instruction currently in EX
  input  wire logic                   exe_m2reg,
  input  wire logic                   exe_wreg,
  input  wire logic [4:0]             exe_rn,
  // forwarding sources
  input  wire logic                   mem_wreg,
  input  wire logic [4:0]             mem_rn,
  input  wire logic [31:0]            mem_data,
  input  wire logic                   wb_wreg,
  input  wire logic [4:0]             wb_rn,
  input  wire logic [31:0]            wb_data,
  input  wire logic                   flush,
  // execute side
  alu_operand_stage_if.master         ex,
  output logic [STALL_CNT_W-1:0]      stall_cnt
);

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic        uses_rs;
  logic        uses_rt;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;
  logic [31:0] a_next;
  logic [31:0] b_next;
  logic        hazard;
  logic        accept;

  assign uses_rs = ~shift;
  assign uses_rt = ~aluimm;

  // Forward the newest in-flight result; MEM is younger than WB, r0 never forwards.
  always_comb begin
    fwd_rs = rs_data;
    fwd_rt = rt_data;
    if (mem_wreg && (mem_rn == rs_num) && (rs_num != 5'd0))
      fwd_rs = mem_data;
    else if (wb_wreg && (wb_rn == rs_num) && (rs_num != 5'd0))
      fwd_rs = wb_data;
    if (mem_wreg && (mem_rn == rt_num) && (rt_num != 5'd0))
      fwd_rt = mem_data;
    else if (wb_wreg && (wb_rn == rt_num) && (rt_num != 5'd0))
      fwd_rt = wb_data;
  end

  // Operand select: shift amount replaces a, extended immediate replaces b.
  always_comb begin
    a_next = shift ? {27'b0, sa} : fwd_rs;
    if (aluimm)
      b_next = sext ? {{16{imm[15]}}, imm} : {16'b0, imm};
    else
      b_next = fwd_rt;
  end

  // A load in EX cannot forward yet; hold decode if it reads the load target.
  always_comb begin
    hazard = in_valid && exe_m2reg && exe_wreg && (exe_rn != 5'd0) &&
             ((uses_rs && (exe_rn == rs_num)) || (uses_rt && (exe_rn == rt_num)));
    in_ready = resetn && !flush && !hazard && (!ex.out_valid || ex.out_ready);
    accept   = in_valid && in_ready;
  end

  // Pipeline register: flush kills the held op, accept loads, consume empties.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ex.out_valid <= 1'b0;
      ex.a         <= 32'd0;
      ex.b         <= 32'd0;
      ex.aluc      <= 4'd0;
      ex.wreg_out  <= 1'b0;
      ex.rn_out    <= 5'd0;
    end else if (flush) begin
      ex.out_valid <= 1'b0;
    end else if (accept) begin
      ex.out_valid <= 1'b1;
      ex.a         <= a_next;
      ex.b         <= b_next;
      ex.aluc      <= aluc_in;
      ex.wreg_out  <= wreg_in;
      ex.rn_out    <= rn_in;
    end else if (ex.out_valid && ex.out_ready) begin
      ex.out_valid <= 1'b0;
    end
  end

  // Saturating count of load-use stall cycles; a flush cycle is not a stall.
  always_ff @(posedge clock) begin
    if (!resetn)
      stall_cnt <= '0;
    else if (hazard && !flush && (stall_cnt != CNT_MAX))
      stall_cnt <= stall_cnt + CNT_ONE;
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_stage
// Description : Self-checking bench for alu_operand_stage: directed cases
//               plus randomized cycles against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;
  localparam int CW = 4;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, in_valid, in_ready;
  logic [4:0]  rs_num, rt_num, sa, rn_in, exe_rn, mem_rn, wb_rn;
  logic [31:0] rs_data, rt_data, mem_data, wb_data;
  logic [15:0] imm;
  logic [3:0]  aluc_in;
  logic        shift, aluimm, sext, wreg_in, exe_m2reg, exe_wreg;
  logic        mem_wreg, wb_wreg, flush;
  logic [CW-1:0] stall_cnt;

  alu_operand_stage_if ex ();

  alu_operand_stage #(.STALL_CNT_W(CW)) dut (
    .clock(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs_num(rs_num), .rt_num(rt_num), .rs_data(rs_data), .rt_data(rt_data),
    .imm(imm), .sa(sa), .aluc_in(aluc_in), .shift(shift), .aluimm(aluimm),
    .sext(sext), .wreg_in(wreg_in), .rn_in(rn_in),
    .exe_m2reg(exe_m2reg), .exe_wreg(exe_wreg), .exe_rn(exe_rn),
    .mem_wreg(mem_wreg), .mem_rn(mem_rn), .mem_data(mem_data),
    .wb_wreg(wb_wreg), .wb_rn(wb_rn), .wb_data(wb_data),
    .flush(flush), .ex(ex), .stall_cnt(stall_cnt)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  logic        m_valid = 1'b0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [3:0]  m_aluc = '0;
  logic        m_wreg = 1'b0;
  logic [4:0]  m_rn = '0;
  int          m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // value a source register reads, taking the youngest in-flight writer
  function automatic logic [31:0] operand_value(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return rf;
    if (mem_wreg && mem_rn == r) return mem_data;
    if (wb_wreg && wb_rn == r) return wb_data;
    return rf;
  endfunction

  // does the presented instruction read what the EX load will produce?
  function automatic logic load_use();
    logic reads_rs, reads_rt;
    reads_rs = !shift && rs_num == exe_rn;
    reads_rt = !aluimm && rt_num == exe_rn;
    return in_valid && exe_m2reg && exe_wreg && exe_rn != 0 && (reads_rs || reads_rt);
  endfunction

  task automatic idle();
    resetn = 1; in_valid = 0; rs_num = 0; rt_num = 0; rs_data = 0; rt_data = 0;
    imm = 0; sa = 0; aluc_in = 0; shift = 0; aluimm = 0; sext = 0; wreg_in = 0;
    rn_in = 0; exe_m2reg = 0; exe_wreg = 0; exe_rn = 0; mem_wreg = 0; mem_rn = 0;
    mem_data = 0; wb_wreg = 0; wb_rn = 0; wb_data = 0; flush = 0; ex.out_ready = 1;
  endtask

  // one clock: check in_ready mid-cycle, advance model, check registers after edge
  task automatic cyc();
    logic haz, rdy;
    logic [31:0] na, nb;
    @(negedge clk); #1;
    haz = load_use();
    rdy = resetn && !flush && !haz && (!m_valid || ex.out_ready);
    check("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    na = shift ? 32'(sa) : operand_value(rs_num, rs_data);
    if (aluimm) nb = sext ? 32'($signed(imm)) : 32'(imm);
    else        nb = operand_value(rt_num, rt_data);
    if (!resetn) begin
      m_valid = 0; m_a = 0; m_b = 0; m_aluc = 0; m_wreg = 0; m_rn = 0; m_cnt = 0;
    end else begin
      if (haz && !flush) m_cnt = (m_cnt >= CNT_SAT) ? CNT_SAT : m_cnt + 1;
      if (flush) m_valid = 0;
      else if (in_valid && rdy) begin
        m_valid = 1; m_a = na; m_b = nb; m_aluc = aluc_in; m_wreg = wreg_in; m_rn = rn_in;
      end else if (m_valid && ex.out_ready) m_valid = 0;
    end
    @(posedge clk); #1;
    check("out_valid", {31'b0, ex.out_valid}, {31'b0, m_valid});
    check("a", ex.a, m_a);
    check("b", ex.b, m_b);
    check("aluc", {28'b0, ex.aluc}, {28'b0, m_aluc});
    check("wreg_out", {31'b0, ex.wreg_out}, {31'b0, m_wreg});
    check("rn_out", {27'b0, ex.rn_out}, {27'b0, m_rn});
    check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
  endtask

  initial begin
    idle();
    // reset for two cycles, then idle
    resetn = 0; cyc(); cyc();
    idle(); cyc();
    check("rst_valid", {31'b0, ex.out_valid}, 32'd0);
    check("rst_a", ex.a, 32'd0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk); check("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // ADD
    in_valid = 1; rs_num = 1; rt_num = 2; rs_data = 5; rt_data = 7; aluc_in = 4'b0000;
    wreg_in = 1; rn_in = 9; cyc();
    check("add_valid", {31'b0, ex.out_valid}, 32'd1);
    check("add_a", ex.a, 32'd5);
    check("add_b", ex.b, 32'd7);

    // immediate / shift selection
    aluimm = 1; sext = 1; imm = 16'h8000; cyc();
    check("imm_sext", ex.b, 32'hFFFF8000);
    sext = 0; cyc();
    check("imm_zext", ex.b, 32'h00008000);
    shift = 1; sa = 5'd31; cyc();
    check("shift_sa", ex.a, 32'd31);

    // forwarding priority and r0
    shift = 0; rs_num = 3; mem_rn = 3; wb_rn = 3; mem_wreg = 1; wb_wreg = 1;
    mem_data = 32'hAAAA; wb_data = 32'hBBBB; rs_data = 32'h1234; cyc();
    check("fwd_mem_pri", ex.a, 32'hAAAA);
    rs_num = 0; mem_rn = 0; wb_rn = 0; cyc();
    check("fwd_r0", ex.a, 32'h1234);

    // load-use on rt for 3 cycles, then a flush+hazard cycle, then release
    idle(); in_valid = 1; rs_num = 1; rs_data = 32'h11; rt_num = 4; rt_data = 32'h44;
    exe_m2reg = 1; exe_wreg = 1; exe_rn = 4;
    for (int i = 0; i < 3; i++) cyc();
    check("lu_cnt", 32'(stall_cnt), 32'd3);
    flush = 1; cyc();
    check("flush_haz_cnt", 32'(stall_cnt), 32'd3);
    flush = 0; exe_m2reg = 0; cyc();
    check("lu_accept", {31'b0, ex.out_valid}, 32'd1);
    check("lu_b", ex.b, 32'h44);

    // downstream backpressure, then flush
    ex.out_ready = 0; rs_data = 32'h99; rt_data = 32'h77; aluc_in = 4'hF;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("bp_a", ex.a, 32'h11);
      check("bp_b", ex.b, 32'h44);
      check("bp_aluc", {28'b0, ex.aluc}, 32'd0);
    end
    flush = 1; cyc();
    check("flush_valid", {31'b0, ex.out_valid}, 32'd0);
    check("flush_a", ex.a, 32'h11);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      resetn    = ($urandom_range(0, 99) != 0);
      in_valid  = $urandom_range(0, 3) != 0;
      rs_num    = 5'($urandom_range(0, 3));
      rt_num    = 5'($urandom_range(0, 3));
      rs_data   = $urandom; rt_data = $urandom;
      imm       = 16'($urandom); sa = 5'($urandom); aluc_in = 4'($urandom);
      shift     = $urandom_range(0, 3) == 0;
      aluimm    = $urandom_range(0, 2) == 0;
      sext      = 1'($urandom);
      wreg_in   = 1'($urandom); rn_in = 5'($urandom);
      exe_m2reg = $urandom_range(0, 2) == 0; exe_wreg = 1'($urandom);
      exe_rn    = 5'($urandom_range(0, 3));
      mem_wreg  = 1'($urandom); mem_rn = 5'($urandom_range(0, 3)); mem_data = $urandom;
      wb_wreg   = 1'($urandom); wb_rn = 5'($urandom_range(0, 3)); wb_data = $urandom;
      flush     = $urandom_range(0, 19) == 0;
      ex.out_ready = $urandom_range(0, 3) != 0;
      cyc();
    end

    // saturation of the stall counter
    idle(); resetn = 0; cyc();
    idle(); in_valid = 1; rs_num = 6; exe_m2reg = 1; exe_wreg = 1; exe_rn = 6;
    for (int i = 0; i < CNT_SAT + 5; i++) cyc();
    check("cnt_sat", 32'(stall_cnt), 32'(CNT_SAT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Decode-to-execute pipeline register that feeds the ALU its operands `a`, `b` and the 4-bit `aluc` code.
- Resolves register-source operands by forwarding from the MEM and WB stages.
- Selects the shift amount or the extended immediate as an operand.
- Detects load-use hazards and stalls upstream.
- Exchanges valid/ready handshakes with the decode stage (upstream) and the execute stage (downstream), and accepts a pipeline flush.

Parameters:
- STALL_CNT_W, 16, width of the saturating load-use stall counter.

Ports:
- clock  in  1  single clock; all state updates on rising edge
- resetn  in  1  synchronous active-low reset, sampled on rising edge of clock
- in_valid  in  1  decode stage presents an instruction
- in_ready  out  1  stage accepts the presented instruction this cycle
- rs_num  in  5  source register number of a
- rt_num  in  5  source register number of b
- rs_data  in  32  register-file read of rs
- rt_data  in  32  register-file read of rt
- imm  in  16  instruction immediate
- sa  in  5  shift amount field
- aluc_in  in  4  ALU control code, passed through unchanged
- shift  in  1  a = zero-extended sa instead of rs
- aluimm  in  1  b = extended imm instead of rt
- sext  in  1  1 = sign-extend imm, 0 = zero-extend
- wreg_in  in  1  instruction writes a register
- rn_in  in  5  destination register number
- exe_m2reg  in  1  instruction currently in EX is a load
- exe_wreg  in  1  instruction in EX writes a register
- exe_rn  in  5  destination of instruction in EX
- mem_wreg  in  1  MEM-stage instruction writes a register
- mem_rn  in  5  MEM-stage destination
- mem_data  in  32  MEM-stage result
- wb_wreg  in  1  WB-stage instruction writes a register
- wb_rn  in  5  WB-stage destination
- wb_data  in  32  WB-stage result
- flush  in  1  discard held and presented instructions
- out_valid  out  1  a/b/aluc hold a valid operation
- out_ready  in  1  execute stage consumes the operation
- a  out  32  ALU operand a
- b  out  32  ALU operand b
- aluc  out  4  ALU control code
- wreg_out  out  1  registered wreg_in
- rn_out  out  5  registered rn_in
- stall_cnt  out  STALL_CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (resetn = 0 at rising edge): out_valid, a, b, aluc, wreg_out, rn_out and stall_cnt all go to 0. in_ready is combinational and is 0 while resetn = 0.
- Operand usage:
  - uses_rs = ~shift.
  - uses_rt = ~aluimm.
- Forwarding, combinational, applied independently to the rs and rt paths:
  - MEM match (mem_wreg & mem_rn == src & src != 0) → mem_data.
  - Else WB match (wb_wreg & wb_rn == src & src != 0) → wb_data.
  - Else register-file data.
  - MEM has priority over WB. Register 0 is never forwarded.
- Operand select:
  - a_next = shift ? {27'b0, sa} : fwd_rs.
  - b_next = aluimm ? (sext ? {{16{imm[15]}}, imm} : {16'b0, imm}) : fwd_rt.
- Hazard: hazard = in_valid & exe_m2reg & exe_wreg & exe_rn != 0 & ((uses_rs & exe_rn == rs_num) | (uses_rt & exe_rn == rt_num)).
- Handshake: in_ready = resetn & ~flush & ~hazard & (~out_valid | out_ready). Accept = in_valid & in_ready.
- Register update, in priority order:
  1. Reset.
  2. Flush: out_valid ← 0; the presented instruction is not accepted; other output registers hold.
  3. Accept: a, b, aluc, wreg_out, rn_out ← next values; out_valid ← 1.
  4. out_valid & out_ready without accept: out_valid ← 0.
  5. Otherwise all registers hold.
- Latency and throughput: 1 cycle from accept to out_valid. Back-to-back accepts sustain 1 op/cycle when out_ready = 1.
- Downstream stall: while out_valid & ~out_ready, a/b/aluc and the other outputs are stable and in_ready = 0.
- Stall counter: stall_cnt increments by 1 on each cycle with hazard = 1 and flush = 0. It saturates at all-ones, with no wrap-around.
- Simultaneous events:
  - Flush + hazard: flush wins and stall_cnt does not increment.
  - Hazard + downstream consume: out_valid drops, so a bubble is inserted.
- Forwarding uses data values sampled in the accept cycle only. The held operands are never re-forwarded while stalled downstream.

Test Plan:
- Reset then idle: resetn = 0 for 2 cycles, then 1 → out_valid = 0, a = b = 0, stall_cnt = 0. With in_valid = 0, in_ready = 1.
- ADD accept: rs_data = 5, rt_data = 7, aluc_in = 0000, shift = aluimm = 0, out_ready = 1 → next cycle out_valid = 1, a = 5, b = 7, aluc = 0000.
- Immediate and shift selection:
  - imm = 16'h8000, aluimm = 1, sext = 1 → b = 32'hFFFF8000.
  - With sext = 0 → b = 32'h00008000.
  - shift = 1, sa = 31 → a = 32'd31.
- Forwarding priority: rs_num = 3, mem_rn = wb_rn = 3, both wreg = 1, mem_data = 32'hAAAA, wb_data = 32'hBBBB → a = 32'hAAAA.
  - With rs_num = 0 and both stages targeting register 0 → a = rs_data.
- Load-use: exe_m2reg = exe_wreg = 1, exe_rn = rt_num = 4, aluimm = 0 for 3 cycles → in_ready = 0 for those cycles, stall_cnt = 3. Accept happens on the cycle exe_m2reg falls.
- Backpressure and flush:
  - out_valid = 1, out_ready = 0 for 4 cycles → a/b/aluc stable and in_ready = 0.
  - Then flush = 1 → out_valid = 0 next cycle, and the presented instruction is not captured.
